// File: rtl/adc_multi_capture.sv
`default_nettype none
// ============================================================================
// adc_multi_capture : shared-CNVST/SCLK multi-channel serial ADC capture with
// a first-word-fall-through sample FIFO. Optional macro: ADC_CAP_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module adc_multi_capture #(
    parameter int DATA_W   = 16,
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 64,
    parameter int TIMEOUT  = 140,
    parameter int CNV_HIGH = 2
) (
    input  logic                     SYSCLK,
    input  logic                     RST_N,
    input  logic                     start,
    input  logic                     abort,
    input  logic [15:0]              aq_div,
    input  logic [7:0]               sclk_div,
    input  logic [15:0]              num_samples,
    output logic                     AD_CNVST,
    output logic                     AD_SCLK,
    input  logic [NUM_CH-1:0]        AD_SDOUT,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [1:0]               rd_ch,
    output logic                     fifo_empty,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
    output logic                     err_overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_BW = $clog2(DATA_W);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_CONV     = 3'd1;
    localparam logic [2:0] c_WAIT_EOC = 3'd2;
    localparam logic [2:0] c_SHIFT    = 3'd3;
    localparam logic [2:0] c_STORE    = 3'd4;
    localparam logic [2:0] c_WAIT_AQ  = 3'd5;
    localparam logic [2:0] c_DONE     = 3'd6;

    localparam logic [15:0]     c_CNV_LAST = 16'(CNV_HIGH - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_W - 1);
    localparam logic [1:0]      c_CH_LAST  = 2'(NUM_CH - 1);
    localparam logic [c_AW:0]   c_FULL_THR = (c_AW + 1)'(DEPTH - NUM_CH);

    logic [2:0]        r_state;
    logic              r_busy;
    logic              r_done;
    logic              r_err_ov;
    logic [15:0]       r_timer;
    logic [15:0]       r_aq_last;
    logic [7:0]        r_sclk_last;
    logic [15:0]       r_num;
    logic [15:0]       r_conv_num;
    logic [15:0]       r_cnv_cnt;
    logic [7:0]        r_sclk_cnt;
    logic              r_sclk;
    logic [c_BW-1:0]   r_bit_cnt;
    logic [1:0]        r_st_ch;
    logic              r_drop;
    logic [DATA_W-1:0] r_sh [NUM_CH];
`ifdef ADC_CAP_TIMEOUT_EN
    localparam logic [15:0] c_TO_LAST = 16'(TIMEOUT - 1);
    logic              r_err_to;
    logic [15:0]       r_eoc_cnt;
`endif

    logic [DATA_W+1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_AW:0]     r_count;

    logic              w_ovf_now;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic [DATA_W-1:0] w_word;
    logic [DATA_W+1:0] w_head;

    // The drop decision is made once, on the first STORE cycle, and held for the frame
    assign w_ovf_now = (r_count > c_FULL_THR);
    assign w_drop    = (r_st_ch == 2'd0) ? w_ovf_now : r_drop;
    assign w_push    = (r_state == c_STORE) && !w_drop && !abort;
    assign w_pop     = rd_en && (r_count != '0);

    always_comb begin
        w_word = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_st_ch == 2'(c)) w_word = r_sh[c];
        end
    end

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= c_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err_ov    <= 1'b0;
            r_timer     <= '0;
            r_aq_last   <= '0;
            r_sclk_last <= '0;
            r_num       <= '0;
            r_conv_num  <= '0;
            r_cnv_cnt   <= '0;
            r_sclk_cnt  <= '0;
            r_sclk      <= 1'b0;
            r_bit_cnt   <= '0;
            r_st_ch     <= '0;
            r_drop      <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) r_sh[c] <= '0;
`ifdef ADC_CAP_TIMEOUT_EN
            r_err_to    <= 1'b0;
            r_eoc_cnt   <= '0;
`endif
        end else if (abort) begin
            r_state <= c_IDLE;
            r_sclk  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (r_busy) r_timer <= (r_timer == r_aq_last) ? 16'd0 : r_timer + 16'd1;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_CONV;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_err_ov    <= 1'b0;
                        r_timer     <= '0;
                        r_cnv_cnt   <= '0;
                        r_conv_num  <= '0;
                        r_aq_last   <= (aq_div < 16'd64) ? 16'd63 : aq_div - 16'd1;
                        r_sclk_last <= (sclk_div == 8'd0) ? 8'd0 : sclk_div - 8'd1;
                        r_num       <= num_samples;
`ifdef ADC_CAP_TIMEOUT_EN
                        r_err_to    <= 1'b0;
`endif
                    end
                end
                c_CONV: begin
                    if (r_cnv_cnt == c_CNV_LAST) begin
                        r_state <= c_WAIT_EOC;
`ifdef ADC_CAP_TIMEOUT_EN
                        r_eoc_cnt <= '0;
`endif
                    end else begin
                        r_cnv_cnt <= r_cnv_cnt + 16'd1;
                    end
                end
                c_WAIT_EOC: begin
                    if (!AD_SDOUT[0]) begin
                        r_state    <= c_SHIFT;
                        r_sclk_cnt <= '0;
                        r_bit_cnt  <= '0;
                    end
`ifdef ADC_CAP_TIMEOUT_EN
                    else if (r_eoc_cnt == c_TO_LAST) begin
                        r_err_to <= 1'b1;
                        r_state  <= c_DONE;
                    end else begin
                        r_eoc_cnt <= r_eoc_cnt + 16'd1;
                    end
`endif
                end
                c_SHIFT: begin
                    if (r_sclk_cnt == r_sclk_last) begin
                        r_sclk_cnt <= '0;
                        r_sclk     <= !r_sclk;
                        if (!r_sclk) begin
                            for (int c = 0; c < NUM_CH; c++)
                                r_sh[c] <= {r_sh[c][DATA_W-2:0], AD_SDOUT[c]};
                        end else if (r_bit_cnt == c_BIT_LAST) begin
                            r_state <= c_STORE;
                            r_st_ch <= '0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_sclk_cnt <= r_sclk_cnt + 8'd1;
                    end
                end
                c_STORE: begin
                    if (r_st_ch == 2'd0) begin
                        r_drop <= w_ovf_now;
                        if (w_ovf_now) r_err_ov <= 1'b1;
                    end
                    if (r_st_ch == c_CH_LAST) begin
                        r_conv_num <= r_conv_num + 16'd1;
                        if ((r_num != 16'd0) && (r_conv_num + 16'd1 == r_num))
                            r_state <= c_DONE;
                        else
                            r_state <= c_WAIT_AQ;
                    end else begin
                        r_st_ch <= r_st_ch + 2'd1;
                    end
                end
                c_WAIT_AQ: begin
                    if (r_timer == r_aq_last) begin
                        r_state   <= c_CONV;
                        r_cnv_cnt <= '0;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge SYSCLK or negedge RST_N) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_st_ch, w_word};
    end

    assign w_head       = r_mem[r_rd_ptr];
    assign fifo_empty   = (r_count == '0);
    assign fifo_count   = r_count;
    assign rd_data      = fifo_empty ? '0 : w_head[DATA_W-1:0];
    assign rd_ch        = fifo_empty ? 2'd0 : w_head[DATA_W+1:DATA_W];
    assign AD_CNVST     = (r_state == c_CONV);
    assign AD_SCLK      = r_sclk;
    assign busy         = r_busy;
    assign done         = r_done;
    assign err_overflow = r_err_ov;
`ifdef ADC_CAP_TIMEOUT_EN
    assign err_timeout  = r_err_to;
`else
    assign err_timeout  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_multi_capture.sv
`default_nettype none
// ============================================================================
// tb_adc_multi_capture : directed vector bench with a serial ADC model.
// Revision: 1.0
// ============================================================================
module tb_adc_multi_capture;
    localparam int DATA_W   = 16;
    localparam int NUM_CH   = 2;
    localparam int DEPTH    = 64;
    localparam int TIMEOUT  = 140;
    localparam int CNV_HIGH = 2;

    logic              SYSCLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              rd_en = 1'b0;
    logic [15:0]       aq_div = 16'd100;
    logic [7:0]        sclk_div = 8'd1;
    logic [15:0]       num_samples = 16'd0;
    logic              AD_CNVST;
    logic              AD_SCLK;
    logic [NUM_CH-1:0] AD_SDOUT = '1;
    logic [DATA_W-1:0] rd_data;
    logic [1:0]        rd_ch;
    logic              fifo_empty;
    logic [6:0]        fifo_count;
    logic              busy, done, err_timeout, err_overflow;

    adc_multi_capture #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNV_HIGH(CNV_HIGH)
    ) dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N), .start(start), .abort(abort),
        .aq_div(aq_div), .sclk_div(sclk_div), .num_samples(num_samples),
        .AD_CNVST(AD_CNVST), .AD_SCLK(AD_SCLK), .AD_SDOUT(AD_SDOUT),
        .rd_en(rd_en), .rd_data(rd_data), .rd_ch(rd_ch),
        .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .busy(busy), .done(done), .err_timeout(err_timeout), .err_overflow(err_overflow)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ADC model: busy for adc_lat cycles after CNVST, one low EOC cycle, then MSB-first data
    logic [15:0] adc_base [NUM_CH];
    logic [15:0] adc_inc = 16'd0;
    int          adc_lat = 2;
    bit          adc_stuck = 1'b0;
    logic [15:0] m_word [NUM_CH];
    int          m_ph, m_cnt, m_bit, m_idx;
    logic        m_prev_sclk, m_cnv_seen;

    always @(negedge SYSCLK) begin
        if (!RST_N) begin
            m_ph = 0; m_idx = 0; m_cnv_seen = 1'b0; AD_SDOUT = '1;
        end else if (AD_CNVST) begin
            if (!m_cnv_seen) begin
                for (int c = 0; c < NUM_CH; c++) m_word[c] = adc_base[c] + 16'(m_idx) * adc_inc;
                m_idx++;
            end
            m_cnv_seen = 1'b1; m_ph = 1; m_cnt = adc_lat; AD_SDOUT = '1;
        end else begin
            m_cnv_seen = 1'b0;
            case (m_ph)
                1: if (!adc_stuck) begin
                       if (m_cnt == 0) begin AD_SDOUT = '0; m_ph = 2; end
                       else m_cnt--;
                   end
                2: begin
                       for (int c = 0; c < NUM_CH; c++) AD_SDOUT[c] = m_word[c][15];
                       m_bit = 15; m_ph = 3;
                   end
                3: if (m_prev_sclk && !AD_SCLK) begin
                       if (m_bit > 0) begin
                           m_bit--;
                           for (int c = 0; c < NUM_CH; c++) AD_SDOUT[c] = m_word[c][m_bit];
                       end else begin
                           m_ph = 0; AD_SDOUT = '1;
                       end
                   end
                default: ;
            endcase
        end
        m_prev_sclk = AD_SCLK;
    end

    // Timing monitor: CNVST rise spacing/width, timeout latency, peak occupancy
    int   cyc, rise_prev, rise_last, hi_cnt, hi_w, fall_cyc, to_cyc, max_cnt;
    logic prev_cnv, prev_to;

    always @(negedge SYSCLK) begin
        if (!RST_N) begin
            cyc = 0; rise_prev = -1; rise_last = -1; hi_cnt = 0; hi_w = 0;
            fall_cyc = -1; to_cyc = -1; max_cnt = 0; prev_cnv = 1'b0; prev_to = 1'b0;
        end else begin
            cyc++;
            if (AD_CNVST) begin
                if (!prev_cnv) begin rise_prev = rise_last; rise_last = cyc; hi_cnt = 0; end
                hi_cnt++;
            end else if (prev_cnv) begin
                hi_w = hi_cnt; fall_cyc = cyc;
            end
            if (err_timeout && !prev_to) to_cyc = cyc;
            prev_cnv = AD_CNVST; prev_to = err_timeout;
            if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
        end
    end

    task automatic do_reset();
        @(negedge SYSCLK);
        RST_N = 1'b0; start = 1'b0; abort = 1'b0; rd_en = 1'b0;
        repeat (3) @(negedge SYSCLK);
        RST_N = 1'b1;
        @(negedge SYSCLK);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge SYSCLK);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge SYSCLK);
        abort = 1'b0;
    endtask

    typedef struct {
        logic [15:0] aq;
        logic [7:0]  sd;
        logic [15:0] ns;
        logic [15:0] b0, b1, inc;
        int          lat;
        int          exp_cnt;
        int          exp_gap;
    } vec_t;

    vec_t        vt [4];
    logic [17:0] got [$];

    initial begin
        vt[0] = '{16'd250, 8'd1, 16'd3, 16'hA5C3, 16'h1234, 16'h0000, 3, 6, 250};
        vt[1] = '{16'd10,  8'd0, 16'd2, 16'hFFFF, 16'h0000, 16'h0001, 1, 4, 64};
        vt[2] = '{16'd200, 8'd3, 16'd1, 16'h8001, 16'h7FFE, 16'h0000, 5, 2, 0};
        vt[3] = '{16'd64,  8'd2, 16'd4, 16'h0F0F, 16'hF0F0, 16'h0101, 2, 8, 128};

        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_to", err_timeout, 0);
        chk("rst_err_ov", err_overflow, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_rd_ch", rd_ch, 0);
        chk("rst_cnvst", AD_CNVST, 0);
        chk("rst_sclk", AD_SCLK, 0);

        for (int v = 0; v < 4; v++) begin
            int n;
            do_reset();
            adc_base[0] = vt[v].b0; adc_base[1] = vt[v].b1; adc_inc = vt[v].inc; adc_lat = vt[v].lat;
            aq_div = vt[v].aq; sclk_div = vt[v].sd; num_samples = vt[v].ns;
            pulse_start();
            chk("v_busy_run", busy, 1);
            n = 0;
            while (!done && n < 3000) begin @(negedge SYSCLK); n++; end
            chk("v_done_reached", done, 1);
            chk("v_busy_end", busy, 0);
            chk("v_count", fifo_count, vt[v].exp_cnt);
            chk("v_err_ov", err_overflow, 0);
            chk("v_cnv_width", hi_w, CNV_HIGH);
            if (vt[v].exp_gap != 0) chk("v_cnv_gap", rise_last - rise_prev, vt[v].exp_gap);
            for (int k = 0; k < vt[v].exp_cnt; k++) begin
                logic [15:0] ew;
                ew = ((k % 2) == 0 ? vt[v].b0 : vt[v].b1) + 16'(k / 2) * vt[v].inc;
                chk("v_rd_ch", rd_ch, k % 2);
                chk("v_rd_data", rd_data, ew);
                rd_en = 1'b1;
                @(negedge SYSCLK);
                rd_en = 1'b0;
            end
            chk("v_drained", fifo_empty, 1);
        end

        // Overflow: continuous run, no reads; the 33rd frame must be dropped
        begin
            int n;
            do_reset();
            adc_base[0] = 16'hA5C3; adc_base[1] = 16'h1234; adc_inc = 16'd0; adc_lat = 2;
            aq_div = 16'd64; sclk_div = 8'd1; num_samples = 16'd0;
            pulse_start();
            n = 0;
            while (!err_overflow && n < 4000) begin @(negedge SYSCLK); n++; end
            chk("ovf_reached", err_overflow, 1);
            chk("ovf_count_full", fifo_count, DEPTH);
            chk("ovf_busy", busy, 1);
            chk("ovf_done", done, 0);
            repeat (70) @(negedge SYSCLK);
            chk("ovf_count_hold", fifo_count, DEPTH);
            chk("ovf_head_data", rd_data, 16'hA5C3);
            chk("ovf_head_ch", rd_ch, 0);
            pulse_abort();
            chk("ovf_abort_busy", busy, 0);
            chk("ovf_abort_count", fifo_count, DEPTH);
            pulse_start();
            chk("restart_clr_ov", err_overflow, 0);
            chk("restart_busy", busy, 1);
            pulse_abort();
        end

        // Abort while SCLK is toggling
        begin
            int n;
            do_reset();
            adc_base[0] = 16'h5555; adc_base[1] = 16'hAAAA; adc_inc = 16'd0; adc_lat = 2;
            aq_div = 16'd100; sclk_div = 8'd2; num_samples = 16'd1;
            pulse_start();
            n = 0;
            while (!AD_SCLK && n < 200) begin @(negedge SYSCLK); n++; end
            chk("abt_shift_reached", AD_SCLK, 1);
            repeat (5) @(negedge SYSCLK);
            pulse_abort();
            chk("abt_busy", busy, 0);
            chk("abt_sclk", AD_SCLK, 0);
            chk("abt_cnvst", AD_CNVST, 0);
            chk("abt_done", done, 0);
            chk("abt_count", fifo_count, 0);
            repeat (100) @(negedge SYSCLK);
            chk("abt_count_later", fifo_count, 0);
            chk("abt_idle_later", busy, 0);
        end

        // End-of-conversion never arrives
        begin
            do_reset();
            adc_stuck = 1'b1; num_samples = 16'd1; aq_div = 16'd100; sclk_div = 8'd1;
            pulse_start();
`ifdef ADC_CAP_TIMEOUT_EN
            begin
                int n;
                n = 0;
                while (!err_timeout && n < 400) begin @(negedge SYSCLK); n++; end
                chk("to_reached", err_timeout, 1);
                chk("to_latency", to_cyc - fall_cyc, TIMEOUT);
                @(negedge SYSCLK);
                chk("to_done", done, 1);
                chk("to_busy", busy, 0);
                chk("to_count", fifo_count, 0);
            end
`else
            repeat (400) @(negedge SYSCLK);
            chk("to_disabled_flag", err_timeout, 0);
            chk("to_disabled_busy", busy, 1);
            chk("to_disabled_done", done, 0);
            pulse_abort();
            chk("to_disabled_count", fifo_count, 0);
`endif
            adc_stuck = 1'b0;
        end

        // Continuous capture with rd_en held high
        begin
            int n;
            do_reset();
            adc_base[0] = 16'h1000; adc_base[1] = 16'h2000; adc_inc = 16'd1; adc_lat = 1;
            aq_div = 16'd64; sclk_div = 8'd1; num_samples = 16'd0;
            got.delete();
            rd_en = 1'b1;
            pulse_start();
            n = 0;
            while (got.size() < 10 && n < 800) begin
                if (!fifo_empty) got.push_back({rd_ch, rd_data});
                @(negedge SYSCLK);
                n++;
            end
            pulse_abort();
            rd_en = 1'b0;
            chk("rd_words_seen", got.size() >= 10, 1);
            chk("rd_max_count", max_cnt <= NUM_CH, 1);
            for (int k = 0; k < got.size() && k < 10; k++) begin
                logic [17:0] ew;
                ew = {2'(k % 2), ((k % 2) == 0 ? 16'h1000 : 16'h2000) + 16'(k / 2)};
                chk("rd_order", got[k], ew);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/adc_multi_capture.md
ADC_MULTI_CAPTURE -- requirements
Module: adc_multi_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 16, conversion result width in bits (8..24).
REQ-002 SHALL have parameter NUM_CH, default 2, number of ADCs sharing AD_CNVST/AD_SCLK, each with its own data line (1..4).
REQ-003 SHALL have parameter DEPTH, default 64, sample FIFO depth in words (power of 2, 4..1024).
REQ-004 SHALL have parameter TIMEOUT, default 140, maximum SYSCLK cycles to wait for conversion end.
REQ-005 SHALL have parameter CNV_HIGH, default 2, AD_CNVST pulse width in SYSCLK cycles (>=1).
REQ-006 Clocking and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-007 SYSCLK  in  1  sole clock, all logic on rising edge.
REQ-008 RST_N  in  1  asynchronous active-low reset.
REQ-009 start  in  1  one-cycle pulse, begins a capture run; ignored while busy.
REQ-010 abort  in  1  terminates a run; higher priority than start.
REQ-011 aq_div  in  16  conversion period in SYSCLK cycles, sampled at start (values <64 treated as 64).
REQ-012 sclk_div  in  8  SCLK half-period in SYSCLK cycles, sampled at start (0 treated as 1).
REQ-013 num_samples  in  16  conversions per run; 0 = continuous until abort.
REQ-014 AD_CNVST  out  1  conversion start to all ADCs.
REQ-015 AD_SCLK  out  1  shared serial clock, idle low.
REQ-016 AD_SDOUT  in  NUM_CH  serial data, bit i from ADC i, MSB first.
REQ-017 rd_en  in  1  pop FIFO head.
REQ-018 rd_data  out  DATA_W  FIFO head sample (first-word-fall-through).
REQ-019 rd_ch  out  2  channel index of head sample.
REQ-020 fifo_empty  out  1; fifo_count  out  log2(DEPTH)+1  occupancy.
REQ-021 busy, done, err_timeout, err_overflow  out  1 each  status flags.

Function
REQ-022 FSM states SHALL be IDLE, CONV, WAIT_EOC, SHIFT, STORE, WAIT_AQ, DONE.
REQ-023 IDLE->CONV on start; busy=1 and done/err flags cleared the same edge; period timer restarts at 0.
REQ-024 CONV SHALL drive AD_CNVST=1 for exactly CNV_HIGH cycles, then enter WAIT_EOC.
REQ-025 WAIT_EOC SHALL exit to SHIFT when AD_SDOUT[0]=0; after TIMEOUT cycles with AD_SDOUT[0]=1 SHALL set err_timeout and enter DONE.
REQ-026 SHIFT SHALL emit DATA_W SCLK periods (sclk_div cycles low then high); all NUM_CH lines sampled in the cycle SCLK rises; AD_SCLK low on exit.
REQ-027 STORE SHALL push NUM_CH words, one per cycle, channel 0 first, rd_ch = channel index.
REQ-028 If free FIFO slots < NUM_CH at STORE entry, the whole frame SHALL be dropped and err_overflow set sticky; run continues.
REQ-029 After STORE: conversion count reached (num_samples != 0) -> DONE, else WAIT_AQ; WAIT_AQ -> CONV when period timer reaches aq_div-1 and wraps.
REQ-030 If a frame exceeds aq_div, the next CONV SHALL start at the next timer wrap (no back-to-back overlap).
REQ-031 DONE SHALL clear busy, set done for one cycle-plus-sticky until next start, return to IDLE.
REQ-032 abort in any state SHALL next edge force IDLE, AD_CNVST=0, AD_SCLK=0, busy=0, done=0; FIFO contents kept.
REQ-033 Simultaneous push and rd_en SHALL leave fifo_count unchanged; rd_en on empty SHALL be ignored; pointers wrap modulo DEPTH.
REQ-034 rd_data/rd_ch SHALL reflect the head word combinationally from registered FIFO state; undefined-but-stable when empty.

Reset
REQ-035 RST_N low SHALL force IDLE, AD_CNVST=0, AD_SCLK=0, busy=0, done=0, err flags=0, FIFO empty (fifo_count=0), timers 0, rd_data=0, rd_ch=0.
REQ-036 Reset mid-SHIFT SHALL drop the partial frame with no FIFO write.

Configuration
REQ-037 Macro ADC_CAP_TIMEOUT_EN defined: REQ-025 timeout active. Undefined: WAIT_EOC waits indefinitely, err_timeout tied 0.

Verification
REQ-038 DATA_W=16, NUM_CH=2, num_samples=3, ADC models return 0xA5C3/0x1234 -> 6 FIFO words alternating ch0/ch1 with those values, done=1.
REQ-039 aq_div=250 -> rising AD_CNVST edges exactly 250 cycles apart; CNVST high width = CNV_HIGH.
REQ-040 AD_SDOUT[0] held high (timeout enabled, TIMEOUT=140) -> err_timeout=1 at cycle 140 of WAIT_EOC, no FIFO write.
REQ-041 DEPTH=4, NUM_CH=2, continuous, no reads -> 2 frames stored, third dropped, err_overflow=1, fifo_count=4.
REQ-042 abort asserted mid-SHIFT -> next cycle IDLE, AD_SCLK=0, busy=0, fifo_count unchanged.
REQ-043 rd_en held during continuous capture with pushes -> fifo_count never exceeds NUM_CH, read order matches write order.
